// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//
// Purpose:
//   Instruction fetch stage of the MIPS pipeline.
//   - Holds the program counter and drives the instruction-memory address.
//   - Captures the fetched word, its PC and PC+4 into the IF/ID register.
//   - Exports the low 16 bits of the held instruction as the immediate for
//     the decode-stage sign extender.
//   - Supports a hazard stall, a flush, and a branch/jump redirect.
//
// Ports:
//   clk_i             - system clock, rising edge
//   rst_i             - asynchronous reset, active LOW
//   stall_i           - hold PC and IF/ID contents
//   flush_i           - squash the instruction being written into IF/ID
//   redirect_i        - taken branch / jump, load PC from redirect_target_i
//   redirect_target_i - new PC (low two bits are ignored)
//   imem_addr_o       - instruction memory address (equals PC register)
//   imem_data_i       - instruction word at imem_addr_o, same-cycle read
//   pc_o              - current PC register
//   ifid_pc_o         - PC of the instruction held in IF/ID
//   ifid_pc_plus4_o   - that PC + 4
//   ifid_instr_o      - instruction held in IF/ID
//   ifid_imm16_o      - ifid_instr_o[15:0], feeds the sign extender
//   ifid_valid_o      - IF/ID holds a real (non-squashed) instruction
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic [31:0] ifid_instr_o,
  output logic [15:0] ifid_imm16_o,
  output logic        ifid_valid_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus4;
  logic        squash;

  // Sequential increment wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // A redirect squashes the slot being fetched, just like an explicit flush.
  assign squash = flush_i | redirect_i;

  // Next PC: a redirect beats a stall so a taken branch is never lost while
  // the hazard unit is holding the pipe. Targets are forced word aligned.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_i) begin
      pc_d = {redirect_target_i[31:2], 2'b00};
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  // Next IF/ID contents. On a squash the PC fields are still loaded so the
  // bubble carries a meaningful address for debug, but the slot is invalid.
  always_comb begin
    ifid_pc_d       = pc_q;
    ifid_pc_plus4_d = pc_plus4;
    ifid_instr_d    = imem_data_i;
    ifid_valid_d    = 1'b1;
    if (squash) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (stall_i) begin
      ifid_pc_d       = ifid_pc_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_valid_d    = ifid_valid_q;
    end
  end

  // State registers; reset acts immediately, independent of the clock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q            <= RESET_PC;
      ifid_pc_q       <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign pc_o            = pc_q;
  assign ifid_pc_o       = ifid_pc_q;
  assign ifid_pc_plus4_o = ifid_pc_plus4_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_imm16_o    = ifid_instr_q[15:0];
  assign ifid_valid_o    = ifid_valid_q;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Upstream neighbour of the decode-stage immediate sign extender in the MIPS datapath.
- Holds the program counter and drives the instruction-memory address.
- Captures fetched instruction, PC and PC+4 into an IF/ID pipeline register, and exports instr[15:0] as the 16-bit immediate consumed by the sign extender.
- Supports stall (hazard unit), flush and branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- stall_i  input  1  hold PC and IF/ID contents.
- flush_i  input  1  squash the instruction being written into IF/ID.
- redirect_i  input  1  branch taken / jump; load PC from redirect_target_i.
- redirect_target_i  input  32  new PC.
- imem_addr_o  output  32  instruction memory address, equals PC register (combinational).
- imem_data_i  input  32  instruction word at imem_addr_o, valid same cycle (asynchronous read).
- pc_o  output  32  current PC register.
- ifid_pc_o  output  32  PC of instruction held in IF/ID.
- ifid_pc_plus4_o  output  32  that PC + 4.
- ifid_instr_o  output  32  instruction held in IF/ID.
- ifid_imm16_o  output  16  ifid_instr_o[15:0]; feeds the sign extender.
- ifid_valid_o  output  1  IF/ID holds a real (non-squashed) instruction.

Behaviour:
- All state is updated on posedge clk_i. rst_i low clears state asynchronously, independent of clk_i:
  - PC = RESET_PC.
  - ifid_pc_o = 0, ifid_pc_plus4_o = 0.
  - ifid_instr_o = NOP_INSTR, ifid_valid_o = 0.
- Reset mid-stall or mid-redirect: reset wins immediately. On the first clock edge after rst_i rises, the fetch at RESET_PC is captured.
- PC next-state, in priority order:
  - redirect_i = 1: PC <= {redirect_target_i[31:2], 2'b00}. This applies even when stall_i = 1; the low bits are always forced to zero.
  - else stall_i = 1: PC holds.
  - else: PC <= PC + 32'd4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID next-state, in priority order:
  - flush_i = 1 or redirect_i = 1:
    - ifid_instr_o <= NOP_INSTR, ifid_valid_o <= 0.
    - ifid_pc_o <= PC, ifid_pc_plus4_o <= PC + 4 (debug only).
  - else stall_i = 1: all IF/ID fields hold.
  - else:
    - ifid_instr_o <= imem_data_i, ifid_pc_o <= PC, ifid_pc_plus4_o <= PC + 4.
    - ifid_valid_o <= 1.
- Latency: the instruction at address A appears on ifid_instr_o one cycle after PC = A with no stall. The redirect penalty is one squashed slot.
- ifid_imm16_o and imem_addr_o are purely combinational from registers; there is no extra latency.
- Stall held for N cycles: PC and IF/ID stay constant for N edges. The next un-stalled edge resumes normally with no lost or duplicated instruction.
- stall_i, flush_i and redirect_i asserted together: redirect/flush behaviour applies; stall is ignored.
- Inputs are sampled only at clock edges. Glitches between edges have no effect.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: rst_i low 2 cycles, then high; imem returns 32'h2001_0005 at 0, 32'h2002_FFFF at 4.
  - Response: during reset PC = 0 and valid = 0.
  - Edge 1: ifid_instr = 32'h2001_0005, imm16 = 16'h0005, ifid_pc_plus4 = 4, valid = 1.
  - Edge 2: imm16 = 16'hFFFF, PC = 8.
- Stall:
  - Stimulus: stall_i high for 3 edges at PC = 8.
  - Response: PC stays 8 and IF/ID is unchanged for all 3 edges. On release, the next edge captures the instruction at 8 and PC = 12.
- Redirect:
  - Stimulus: redirect_i = 1, target = 32'h0000_0043 at PC = 12.
  - Response: next PC = 32'h0000_0040, ifid_valid = 0, ifid_instr = NOP_INSTR. The following edge captures the instruction at 0x40.
- Redirect during stall, all controls simultaneous:
  - Stimulus: stall_i = flush_i = redirect_i = 1, target = 32'h100.
  - Response: PC = 32'h100 and IF/ID is squashed (valid = 0).
- Wrap-around:
  - Stimulus: redirect to 32'hFFFF_FFFC, then run 2 edges.
  - Response: PC = 0 after the wrap; ifid_pc = 32'hFFFF_FFFC with ifid_pc_plus4 = 0.
- Asynchronous reset mid-operation:
  - Stimulus: pull rst_i low between clock edges while PC = 32'h20, valid = 1.
  - Response: PC = RESET_PC and valid = 0 immediately, without waiting for a clock edge.
